// File: rtl/uart_rx.sv
// 8N1 serial receiver with a two-register CPU read port.
// Bit timing is derived from a down-counter reloaded every BIT_CYCLES clocks.
module uart_rx #(
  parameter int unsigned BIT_CYCLES = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       re,
  input  logic       addr,
  output logic [7:0] rdata,
  output logic       irq
);

  localparam logic [7:0] BitLast  = 8'(BIT_CYCLES - 1);
  localparam logic [7:0] HalfLast = 8'(BIT_CYCLES / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] bitn_q, bitn_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       ovr_q, ovr_d;
  logic       ferr_q, ferr_d;
  logic       rx_meta_q, rx_meta_d;
  logic       rx_s_q, rx_s_d;

  logic       rd_data;
  logic       busy;
  logic       cnt_zero;

  assign rd_data  = re && !addr;
  assign busy     = (state_q != IDLE);
  assign cnt_zero = (cnt_q == 8'd0);

  always_comb begin
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    bitn_d    = bitn_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;
    ferr_d    = ferr_q;

    // A data read consumes the flags; a delivery on the same edge wins below.
    if (rd_data) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
      ferr_d  = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          cnt_d   = HalfLast;
          state_d = START;
        end
      end
      START: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 8'd1;
        end else if (rx_s_q) begin
          state_d = IDLE;
        end else begin
          cnt_d   = BitLast;
          bitn_d  = 3'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          shreg_d = {rx_s_q, shreg_q[7:1]};
          bitn_d  = bitn_q + 3'd1;
          cnt_d   = BitLast;
          if (bitn_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 8'd1;
        end else if (rx_s_q) begin
          data_d  = shreg_q;
          valid_d = 1'b1;
          ovr_d   = valid_q && !rd_data;
          state_d = IDLE;
        end else begin
          ferr_d  = 1'b1;
          state_d = BREAK;
        end
      end
      BREAK: begin
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      bitn_q    <= 3'd0;
      shreg_q   <= 8'd0;
      data_q    <= 8'd0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bitn_q    <= bitn_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
      ferr_q    <= ferr_d;
    end
  end

  assign rdata = addr ? {4'b0, busy, ferr_q, ovr_q, valid_q} : data_q;
  assign irq   = valid_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized frame-level bench for uart_rx against a register-level model.
// Model tracks data/valid/overrun/ferr from frame outcomes and reads only.
module tb_uart_rx;

  localparam int BC    = 27;
  localparam int HALF  = BC / 2;
  localparam int FRAME = 10 * BC;
  localparam int SAMP  = 2 + HALF + 9 * BC;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       re;
  logic       addr;
  logic [7:0] rdata;
  logic       irq;

  int checks = 0;
  int failures = 0;

  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ovr;
  logic       m_ferr;

  uart_rx #(.BIT_CYCLES(BC)) dut (
    .clk  (clk),
    .reset(reset),
    .rx   (rx),
    .re   (re),
    .addr (addr),
    .rdata(rdata),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] stat(input logic busy);
    return {4'b0, busy, m_ferr, m_ovr, m_valid};
  endfunction

  task automatic m_clear();
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_ferr  = 1'b0;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic a, input logic busy);
    re   = 1'b1;
    addr = a;
    #1;
    if (a) chk("status", 32'(rdata), 32'(stat(busy)));
    else   chk("data", 32'(rdata), 32'(m_data));
    @(negedge clk);
    re   = 1'b0;
    addr = 1'b1;
    if (!a) m_clear();
  endtask

  // slen: start-bit low width in cycles; tail: extra cycles holding the
  // stop-bit level; rd_at/rst_at: cycle of a data read / reset (-1 = none).
  task automatic frame(input logic [7:0] b, input logic stop, input int slen,
                       input int tail, input int rd_at, input int rst_at);
    logic ok;
    logic abort;
    logic pin;
    int   k;
    ok    = (slen > HALF);
    abort = 1'b0;
    for (int c = 0; c < FRAME + tail && !abort; c++) begin
      if (c < slen)         pin = 1'b0;
      else if (c < BC)      pin = 1'b1;
      else if (c < 9 * BC) begin
        k   = c / BC - 1;
        pin = b[k[2:0]];
      end else              pin = stop;
      rx = pin;
      if (c == rst_at) reset = 1'b1;
      if (c == rd_at) begin
        re   = 1'b1;
        addr = 1'b0;
        #1;
        chk("rd_inflight", 32'(rdata), 32'(m_data));
      end
      @(negedge clk);
      re   = 1'b0;
      addr = 1'b1;
      #1;
      if (c == rst_at) begin
        reset  = 1'b0;
        m_data = 8'h00;
        m_clear();
        abort  = 1'b1;
        chk("rst_mid_status", 32'(rdata), 32'(stat(1'b0)));
        chk("rst_mid_irq", 32'(irq), 32'(1'b0));
        addr = 1'b0;
        #1;
        chk("rst_mid_data", 32'(rdata), 32'(m_data));
        addr = 1'b1;
      end else begin
        if (c == rd_at) m_clear();
        if (ok && c == SAMP) begin
          if (stop) begin
            m_ovr   = m_valid;
            m_valid = 1'b1;
            m_data  = b;
          end else begin
            m_ferr = 1'b1;
          end
        end
        if (c == SAMP - 1) chk("irq_pre", 32'(irq), 32'(m_valid));
        if (c == SAMP) begin
          chk("irq_post", 32'(irq), 32'(m_valid));
          chk("stat_stop", 32'(rdata), 32'(stat(ok && !stop)));
        end
        if (c == HALF + 1) chk("busy_start", 32'(rdata[3]), 32'(1'b1));
        if (c == HALF + 2) chk("busy_after_start", 32'(rdata[3]), 32'(ok));
      end
    end
    if (!abort) chk("stat_end", 32'(rdata), 32'(stat(ok && !stop)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] rb;
    logic       rs;
    int         ra;
    int         rt;
    int         rg;

    reset = 1'b1;
    rx    = 1'b1;
    re    = 1'b0;
    addr  = 1'b1;
    m_data = 8'h00;
    m_clear();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_status", 32'(rdata), 32'h00);
    chk("rst_irq", 32'(irq), 32'h0);
    addr = 1'b0;
    #1;
    chk("rst_data", 32'(rdata), 32'h00);
    addr  = 1'b1;
    reset = 1'b0;
    idle(5);

    // back-to-back good bytes, first consumed during the second frame
    frame(8'h55, 1'b1, BC, 0, -1, -1);
    frame(8'hA3, 1'b1, BC, 0, 100, -1);
    idle(3);
    rd(1'b0, 1'b0);
    rd(1'b1, 1'b0);

    // start-bit width boundary: 10 and HALF reject, HALF+1 accepts
    frame(8'hFF, 1'b1, 10, 0, -1, -1);
    frame(8'hFF, 1'b1, HALF, 0, -1, -1);
    frame(8'hFF, 1'b1, HALF + 1, 0, -1, -1);
    idle(3);
    rd(1'b0, 1'b0);
    rd(1'b1, 1'b0);

    // framing error with a long break, then one with a read inside it
    frame(8'h3C, 1'b0, BC, 400, -1, -1);
    idle(4);
    rd(1'b1, 1'b0);
    rd(1'b0, 1'b0);
    rd(1'b1, 1'b0);
    frame(8'hC3, 1'b0, BC, 300, SAMP + 100, -1);
    idle(4);
    rd(1'b1, 1'b0);

    // overrun
    frame(8'h11, 1'b1, BC, 0, -1, -1);
    frame(8'h22, 1'b1, BC, 0, -1, -1);
    idle(2);
    rd(1'b1, 1'b0);
    rd(1'b0, 1'b0);
    rd(1'b1, 1'b0);

    // read on the delivery edge
    frame(8'h66, 1'b1, BC, 0, -1, -1);
    frame(8'h77, 1'b1, BC, 0, SAMP, -1);
    rd(1'b1, 1'b0);
    rd(1'b0, 1'b0);

    // reset during data bit 4, then a clean frame
    frame(8'h5A, 1'b1, BC, 0, -1, 5 * BC + 10);
    idle(5);
    frame(8'h81, 1'b1, BC, 0, -1, -1);
    rd(1'b0, 1'b0);
    rd(1'b1, 1'b0);

    for (int i = 0; i < 24; i++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) ra = int'($urandom_range(0, FRAME - 1));
      else                           ra = -1;
      if (rs) begin
        rt = 0;
        rg = int'($urandom_range(0, 3));
      end else begin
        rt = int'($urandom_range(0, 40));
        rg = int'($urandom_range(4, 8));
      end
      frame(rb, rs, BC, rt, ra, -1);
      if (rg > 0) idle(rg);
      if ($urandom_range(0, 2) == 0) begin
        rd(1'b1, 1'b0);
        rd(1'b0, 1'b0);
      end
    end

    idle(3);
    rd(1'b1, 1'b0);
    rd(1'b0, 1'b0);
    rd(1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
